simd_sequencer: RTL and testbench
=================================

// Module: simd_sequencer
// PURPOSE
//  Parametrised instruction sequencer for the SIMD datapath. It fetches from the instruction BRAM and decodes
//  {opcode, r_addr, a_addr, b_addr}. It issues operand reads to BRAM A/B and presents opcode+valid to the PE array
//  aligned with operand data. It generates BRAM R write enable/address after PE latency.
//  Adds start/busy/done handshake, HALT/NOP opcodes, program repeat count and host-write lockout.
// PARAMETERS
//  INS_ADDR_WIDTH  8   instruction BRAM address width (program depth 2**INS_ADDR_WIDTH)
//  ADDR_WIDTH      10  data BRAM (A/B/R) address width
//  OPCODE_WIDTH    4   opcode field width; all-zeros = NOP, all-ones = HALT, others forwarded to PEs
//  INS_WIDTH       64  instruction word width; fields packed from bit 0: b_addr, a_addr, r_addr, opcode
//  MEM_LAT         1   BRAM read latency in cycles (1..4), identical for INS/A/B
//  PE_LAT          2   PE compute latency, operand-valid to result-valid (>=1)
//  LOOP_WIDTH      8   width of program repeat count
// PORTS
//  clk          in   1               clock
//  rst          in   1               asynchronous active-high reset
//  start        in   1               1-cycle request to run program from pc=0
//  loop_count   in   LOOP_WIDTH      program repetitions, sampled on accepted start; 0 treated as 1
//  busy         out  1               high from accepted start until done
//  done         out  1               1-cycle pulse when last writeback has issued
//  error        out  1               sticky: pc reached last address without HALT; cleared on next start
//  host_lock    out  1               = busy; PS must not write A/B/INS BRAMs while high
//  pc           out  INS_ADDR_WIDTH  instruction BRAM read address
//  ins_rdata    in   INS_WIDTH       instruction BRAM read data
//  bram_a_addr  out  ADDR_WIDTH      BRAM A read address
//  bram_b_addr  out  ADDR_WIDTH      BRAM B read address
//  pe_opcode    out  OPCODE_WIDTH    opcode to PEs, aligned with A/B read data
//  pe_valid     out  1               operands on BRAM A/B dout are valid this cycle
//  bram_r_wen   out  1               BRAM R write enable, aligned with PE result
//  bram_r_addr  out  ADDR_WIDTH      BRAM R write address
// BEHAVIOUR
//  Reset: all outputs and state 0; FSM=IDLE; in-flight pipeline cleared immediately, even mid-program.
//  FSM: IDLE -start-> RUN; RUN -HALT decoded or implicit halt-> DRAIN; DRAIN -pipe empty->
//    RUN if loops_left>1 (loops_left--, pc=0) else DONE; DONE -> IDLE (done=1 this cycle, busy=0 next).
//  start while busy is ignored. busy/host_lock rise the cycle after start.
//  Fetch: in RUN, pc increments by 1 every cycle. A fetch-valid shift register of depth MEM_LAT tags
//    each issued pc. Instruction from pc issued at cycle t is decoded at t+MEM_LAT.
//  Decode at cycle d: a/b addresses registered onto bram_a/b_addr at d+1.
//    pe_opcode/pe_valid asserted at d+1+MEM_LAT.
//    bram_r_wen/bram_r_addr asserted at d+1+MEM_LAT+PE_LAT.
//    Throughput is one instruction per cycle with no stalls.
//  NOP: consumes a slot; pe_valid=0 and bram_r_wen=0 for it. Addresses are don't-care.
//  HALT: no PE/writeback activity. Fetching stops the same cycle. Speculatively fetched words after HALT
//    (up to MEM_LAT) are squashed. pc holds.
//  Implicit halt: pc == 2**INS_ADDR_WIDTH-1 fetched without prior HALT. That word executes normally;
//    pc does not wrap; error set; then treated as HALT.
//  DRAIN ends when no valid operand or writeback is in flight. done is asserted the cycle after the final
//    bram_r_wen.
//  Write-after-read: A/B are read-only during run. Program-order R writes are guaranteed; no hazards.
//  Opcode 1..2**OPCODE_WIDTH-2 are passed through unmodified; decoding them is the PE's job.
// TESTING
//  1 Reset/idle: rst pulse, start=0 -> busy=done=pe_valid=bram_r_wen=0, pc=0.
//  2 Single op: MEM_LAT=1, PE_LAT=2, INS[0]={op3,r5,a7,b9}, INS[1]=HALT, start at cycle 0 ->
//    bram_a_addr=7/b=9 at cycle 3, pe_valid op3 at 4, bram_r_wen addr5 at 6, done at 7.
//  3 Stream: 16 back-to-back ops then HALT -> 16 consecutive bram_r_wen in program order.
//    No wen after HALT squash.
//  4 NOP+loop: prog {op1,NOP,HALT}, loop_count=3 -> exactly 3 writebacks, one done pulse.
//    loop_count=0 -> 1 writeback.
//  5 Implicit halt: INS_ADDR_WIDTH=4, no HALT, all ops -> 16 writebacks, error=1, done pulses.
//    Next start clears error.
//  6 Abort: rst asserted mid-DRAIN with writes in flight -> no further bram_r_wen.
//    start after reset runs cleanly. start while busy is ignored.

Source files
------------

// File: rtl/simd_sequencer_if.sv
// Bus bundle between the SIMD sequencer and its host, instruction BRAM, operand BRAMs and PE array.
// The sequencer uses the slave modport; the host/memory side uses master.
interface simd_sequencer_if #(
    parameter int INS_ADDR_WIDTH = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int OPCODE_WIDTH   = 4,
    parameter int INS_WIDTH      = 64,
    parameter int LOOP_WIDTH     = 8
);
    logic                      start;
    logic [LOOP_WIDTH-1:0]     loop_count;
    logic                      busy;
    logic                      done;
    logic                      error;
    logic                      host_lock;
    logic [INS_ADDR_WIDTH-1:0] pc;
    logic [INS_WIDTH-1:0]      ins_rdata;
    logic [ADDR_WIDTH-1:0]     bram_a_addr;
    logic [ADDR_WIDTH-1:0]     bram_b_addr;
    logic [OPCODE_WIDTH-1:0]   pe_opcode;
    logic                      pe_valid;
    logic                      bram_r_wen;
    logic [ADDR_WIDTH-1:0]     bram_r_addr;

    modport master (
        output start, loop_count, ins_rdata,
        input  busy, done, error, host_lock, pc, bram_a_addr, bram_b_addr,
               pe_opcode, pe_valid, bram_r_wen, bram_r_addr
    );

    modport slave (
        input  start, loop_count, ins_rdata,
        output busy, done, error, host_lock, pc, bram_a_addr, bram_b_addr,
               pe_opcode, pe_valid, bram_r_wen, bram_r_addr
    );
endinterface

// File: rtl/simd_sequencer.sv
// Instruction sequencer for the SIMD datapath: fetch, decode, operand addressing, PE issue and R writeback,
// with start/busy/done handshake, HALT/NOP, program repeat and implicit halt at the last program address.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | fetching one instruction per cycle
// DRAIN | fetch stopped, waiting for in-flight decode/operand/writeback to finish
// DONE  | final writeback issued, done pulse
module simd_sequencer #(
    parameter int INS_ADDR_WIDTH = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int OPCODE_WIDTH   = 4,
    parameter int INS_WIDTH      = 64,
    parameter int MEM_LAT        = 1,
    parameter int PE_LAT         = 2,
    parameter int LOOP_WIDTH     = 8
) (
    input  logic            clk,
    input  logic            rst,
    simd_sequencer_if.slave bus
);
    localparam int FIELD_W = 3 * ADDR_WIDTH + OPCODE_WIDTH;
    localparam int DEPTH   = MEM_LAT + PE_LAT + 1;
    localparam int OPD     = MEM_LAT + 1;
    localparam logic [INS_ADDR_WIDTH-1:0] PC_LAST  = '1;
    localparam logic [OPCODE_WIDTH-1:0]   OP_NOP   = '0;
    localparam logic [OPCODE_WIDTH-1:0]   OP_HALT  = '1;
    localparam logic [LOOP_WIDTH-1:0]     LOOP_ONE = LOOP_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [INS_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [LOOP_WIDTH-1:0]     loops_q, loops_d;
    logic [MEM_LAT-1:0]        fv_q, fv_d;
    logic [MEM_LAT-1:0]        fl_q, fl_d;
    logic [ADDR_WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [DEPTH-1:0]          pv_q, pv_d;
    logic [OPCODE_WIDTH-1:0]   pop_q [OPD];
    logic [OPCODE_WIDTH-1:0]   pop_d [OPD];
    logic [ADDR_WIDTH-1:0]     pr_q [DEPTH];
    logic [ADDR_WIDTH-1:0]     pr_d [DEPTH];
    logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [OPCODE_WIDTH-1:0]   dec_op;
    logic [ADDR_WIDTH-1:0]     dec_r, dec_a, dec_b;
    logic                      dec_vld, dec_last, dec_halt, dec_exec;
    logic                      issue, drain_empty;

    assign dec_b    = bus.ins_rdata[ADDR_WIDTH-1:0];
    assign dec_a    = bus.ins_rdata[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign dec_r    = bus.ins_rdata[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
    assign dec_op   = bus.ins_rdata[3*ADDR_WIDTH +: OPCODE_WIDTH];
    assign dec_vld  = fv_q[MEM_LAT-1];
    assign dec_last = fl_q[MEM_LAT-1];
    assign dec_halt = dec_vld && (dec_op == OP_HALT);
    assign dec_exec = dec_vld && (dec_op != OP_HALT) && (dec_op != OP_NOP);

    generate
        if (INS_WIDTH > FIELD_W) begin : g_ins_hi
            logic unused_ins_hi;
            assign unused_ins_hi = ^bus.ins_rdata[INS_WIDTH-1:FIELD_W];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        loops_d = loops_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        a_d     = a_q;
        b_d     = b_q;
        fv_d    = '0;
        fl_d    = '0;
        pv_d    = '0;

        issue   = (state_q == S_RUN) && !dec_halt;

        // A decoded HALT squashes every younger fetch still in the BRAM pipe.
        fv_d[0] = issue;
        fl_d[0] = issue && (pc_q == PC_LAST);
        for (int i = 1; i < MEM_LAT; i++) begin
            fv_d[i] = fv_q[i-1] && !dec_halt;
            fl_d[i] = fl_q[i-1];
        end

        if (dec_vld) begin
            a_d = dec_a;
            b_d = dec_b;
        end
        pv_d[0]  = dec_exec;
        pop_d[0] = dec_op;
        pr_d[0]  = dec_r;
        for (int i = 1; i < DEPTH; i++) begin
            pv_d[i] = pv_q[i-1];
            pr_d[i] = pr_q[i-1];
        end
        for (int i = 1; i < OPD; i++) begin
            pop_d[i] = pop_q[i-1];
        end

        // True when only the final writeback stage (leaving this cycle) may still be occupied.
        drain_empty = !dec_exec;
        for (int i = 0; i < MEM_LAT - 1; i++) begin
            if (fv_q[i] && !dec_halt) drain_empty = 1'b0;
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (pv_q[i]) drain_empty = 1'b0;
        end

        if (dec_vld && dec_last && !dec_halt) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    loops_d = (bus.loop_count == '0) ? LOOP_ONE : bus.loop_count;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (issue && (pc_q != PC_LAST)) pc_d = pc_q + 1'b1;
                if (dec_halt || (issue && (pc_q == PC_LAST))) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_empty) begin
                    if (loops_q > LOOP_ONE) begin
                        loops_d = loops_q - 1'b1;
                        pc_d    = '0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            loops_q <= '0;
            fv_q    <= '0;
            fl_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pv_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < OPD; i++) pop_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++) pr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            loops_q <= loops_d;
            fv_q    <= fv_d;
            fl_q    <= fl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pv_q    <= pv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < OPD; i++) pop_q[i] <= pop_d[i];
            for (int i = 0; i < DEPTH; i++) pr_q[i] <= pr_d[i];
        end
    end

    assign bus.busy        = busy_q;
    assign bus.host_lock   = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = err_q;
    assign bus.pc          = pc_q;
    assign bus.bram_a_addr = a_q;
    assign bus.bram_b_addr = b_q;
    assign bus.pe_valid    = pv_q[MEM_LAT];
    assign bus.pe_opcode   = pop_q[MEM_LAT];
    assign bus.bram_r_wen  = pv_q[DEPTH-1];
    assign bus.bram_r_addr = pr_q[DEPTH-1];
endmodule

// File: tb/tb_simd_sequencer.sv
// Self-checking bench for simd_sequencer: program-level reference model feeds a scoreboard that a
// negedge monitor drains on every pe_valid and bram_r_wen.
module tb_simd_sequencer;
    typedef struct packed {
        logic [3:0] op;
        logic [9:0] a;
        logic [9:0] b;
    } pe_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   t_busy, t_a, t_pe, t_wen, t_wen_last, t_done, n_wen;
    logic [9:0] watch_a = 10'd0;

    logic [63:0] ins_mem [256];
    logic [9:0]  wb_q [$];
    pe_exp_t     pe_q [$];
    logic [9:0]  a_prev = '0, b_prev = '0;

    simd_sequencer_if bus ();

    simd_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction BRAM, one cycle read latency
    always @(posedge clk) bus.ins_rdata <= ins_mem[bus.pc];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor; operand addresses are compared one BRAM latency before pe_valid.
    always @(negedge clk) begin
        logic [9:0] ewb;
        pe_exp_t    epe;
        if (!rst) begin
            if (bus.done) done_cnt++;
            if (bus.bram_r_wen) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wen: got addr %0h expected no write", bus.bram_r_addr);
                end else begin
                    ewb = wb_q.pop_front();
                    chk("wb_addr", 64'(bus.bram_r_addr), 64'(ewb));
                end
            end
            if (bus.pe_valid) begin
                if (pe_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pe_valid: got op %0h expected none", bus.pe_opcode);
                end else begin
                    epe = pe_q.pop_front();
                    chk("pe_opcode", 64'(bus.pe_opcode), 64'(epe.op));
                    chk("pe_a_addr", 64'(a_prev), 64'(epe.a));
                    chk("pe_b_addr", 64'(b_prev), 64'(epe.b));
                end
            end
        end
        a_prev = bus.bram_a_addr;
        b_prev = bus.bram_b_addr;
    end

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [9:0] r,
                                       input logic [9:0] a, input logic [9:0] b);
        logic [31:0] j;
        j = $urandom();
        return {j[29:0], op, r, a, b};
    endfunction

    function automatic logic [9:0] rnd10();
        logic [31:0] t;
        t = $urandom();
        return t[9:0];
    endfunction

    function automatic logic [3:0] rnd_op(input int lo);
        int v;
        v = $urandom_range(lo, 14);
        return 4'(v);
    endfunction

    task automatic fill_junk();
        for (int p = 0; p < 256; p++) ins_mem[p] = mk(rnd_op(1), rnd10(), rnd10(), rnd10());
    endtask

    // Reference: walk the program from address 0 for each repetition; HALT or the last address ends a pass.
    task automatic model_push(input int lc, output bit err);
        int n;
        logic [63:0] w;
        n = (lc == 0) ? 1 : lc;
        err = 1'b0;
        for (int l = 0; l < n; l++) begin
            for (int p = 0; p < 256; p++) begin
                w = ins_mem[p];
                if (w[33:30] == 4'hF) break;
                if (w[33:30] != 4'h0) begin
                    wb_q.push_back(w[29:20]);
                    pe_q.push_back({w[33:30], w[19:10], w[9:0]});
                end
                if (p == 255) err = 1'b1;
            end
        end
    endtask

    task automatic run_prog(input int lc, input bit extra);
        bit exp_err;
        int s, rel, hl_bad;
        model_push(lc, exp_err);
        @(posedge clk); #1;
        chk("idle_before_start", 64'(bus.busy), 64'(0));
        bus.loop_count = 8'(lc);
        bus.start = 1'b1;
        s = cyc;
        done_cnt = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        t_busy = -1; t_a = -1; t_pe = -1; t_wen = -1; t_wen_last = -1; t_done = -1;
        n_wen = 0; hl_bad = 0;
        for (int k = 0; k < 3000 && t_done < 0; k++) begin
            @(negedge clk);
            rel = cyc - s;
            if (bus.busy && t_busy < 0) t_busy = rel;
            if (bus.bram_a_addr == watch_a && t_a < 0) t_a = rel;
            if (bus.pe_valid && t_pe < 0) t_pe = rel;
            if (bus.bram_r_wen) begin
                if (t_wen < 0) t_wen = rel;
                t_wen_last = rel;
                n_wen++;
            end
            if (bus.done) t_done = rel;
            if (bus.host_lock !== bus.busy) hl_bad++;
            if (extra) begin
                bus.start = (rel == 4);
                bus.loop_count = 8'd7;
            end
        end
        bus.start = 1'b0;
        chk("done_seen", 64'(t_done >= 0), 64'(1));
        chk("error_flag", 64'(bus.error), 64'(exp_err));
        @(negedge clk);
        chk("busy_drop", 64'(bus.busy), 64'(0));
        chk("done_pulses", 64'(done_cnt), 64'(1));
        chk("host_lock_eq_busy", 64'(hl_bad), 64'(0));
        chk("wb_queue_drained", 64'(wb_q.size()), 64'(0));
        chk("pe_queue_drained", 64'(pe_q.size()), 64'(0));
    endtask

    initial begin
        int s, wcnt, len;
        bit dummy;
        bus.start = 1'b0;
        bus.loop_count = '0;
        fill_junk();

        // 1: reset / idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_pe_valid", 64'(bus.pe_valid), 64'(0));
        chk("rst_wen", 64'(bus.bram_r_wen), 64'(0));
        chk("rst_pc", 64'(bus.pc), 64'(0));
        chk("rst_error", 64'(bus.error), 64'(0));
        chk("rst_host_lock", 64'(bus.host_lock), 64'(0));

        // 2: single op timing
        ins_mem[0] = mk(4'd3, 10'd5, 10'd7, 10'd9);
        ins_mem[1] = mk(4'hF, 10'd0, 10'd0, 10'd0);
        watch_a = 10'd7;
        run_prog(1, 1'b0);
        chk("t_busy", 64'(t_busy), 64'(1));
        chk("t_a_addr", 64'(t_a), 64'(3));
        chk("t_pe_valid", 64'(t_pe), 64'(4));
        chk("t_wen", 64'(t_wen), 64'(6));
        chk("t_done", 64'(t_done), 64'(7));
        watch_a = 10'h3FF;

        // 3: 16-op stream, junk ops after HALT must be squashed
        fill_junk();
        for (int p = 0; p < 16; p++) ins_mem[p] = mk(rnd_op(1), 10'(p + 100), rnd10(), rnd10());
        ins_mem[16] = mk(4'hF, rnd10(), rnd10(), rnd10());
        run_prog(1, 1'b0);
        chk("stream_count", 64'(n_wen), 64'(16));
        chk("stream_back_to_back", 64'(t_wen_last - t_wen), 64'(15));

        // 4: NOP + repeat, then loop_count 0
        fill_junk();
        ins_mem[0] = mk(4'd1, 10'd33, 10'd1, 10'd2);
        ins_mem[1] = mk(4'd0, rnd10(), rnd10(), rnd10());
        ins_mem[2] = mk(4'hF, rnd10(), rnd10(), rnd10());
        run_prog(3, 1'b0);
        chk("loop3_writebacks", 64'(n_wen), 64'(3));
        run_prog(0, 1'b0);
        chk("loop0_writebacks", 64'(n_wen), 64'(1));

        // 5: implicit halt at the last address, then a clean run clears error
        fill_junk();
        run_prog(1, 1'b0);
        chk("implicit_writebacks", 64'(n_wen), 64'(256));
        chk("implicit_error", 64'(bus.error), 64'(1));
        ins_mem[0] = mk(4'd6, 10'd44, 10'd4, 10'd8);
        ins_mem[1] = mk(4'hF, 10'd0, 10'd0, 10'd0);
        run_prog(1, 1'b0);
        chk("error_cleared", 64'(bus.error), 64'(0));

        // 6: reset mid-drain with writes in flight
        fill_junk();
        for (int p = 0; p < 8; p++) ins_mem[p] = mk(rnd_op(1), rnd10(), rnd10(), rnd10());
        ins_mem[8] = mk(4'hF, 10'd0, 10'd0, 10'd0);
        model_push(1, dummy);
        @(posedge clk); #1;
        bus.loop_count = 8'd1;
        bus.start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (cyc - s < 11) @(negedge clk);
        #1 rst = 1'b1;
        wb_q.delete();
        pe_q.delete();
        #1;
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_pc", 64'(bus.pc), 64'(0));
        wcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.bram_r_wen) wcnt++;
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.bram_r_wen) wcnt++;
        end
        chk("abort_no_wen", 64'(wcnt), 64'(0));

        // clean run after reset with a start pulse while busy
        for (int p = 0; p < 12; p++) ins_mem[p] = mk(rnd_op(0), rnd10(), rnd10(), rnd10());
        ins_mem[12] = mk(4'hF, 10'd0, 10'd0, 10'd0);
        run_prog(2, 1'b1);

        // 7: random programs
        for (int it = 0; it < 10; it++) begin
            fill_junk();
            len = $urandom_range(0, 40);
            for (int p = 0; p < len; p++) ins_mem[p] = mk(rnd_op(0), rnd10(), rnd10(), rnd10());
            ins_mem[len] = mk(4'hF, rnd10(), rnd10(), rnd10());
            run_prog($urandom_range(0, 3), it[0]);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
